// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: drives DAC trial codes, samples the comparator, returns the code.
// Optional SAR_ADC_CTRL_AVG_EN: four conversions per start, result is their truncated average.
module sar_adc_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             cmp_i,
    output logic             sample_o,
    output logic [WIDTH-1:0] dac_code_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CYCLES);

    typedef enum logic [2:0] {IDLE, SAMPLE, TRIAL, ACCUM, DONE} state_t;

    state_t           state, state_n;
    logic [IW-1:0]    idx, idx_n;
    logic [3:0]       cnt, cnt_n;
    logic [WIDTH-1:0] dac_n, result_n, mask, code_dec;
    logic             sample_n, busy_n, done_n;
`ifdef SAR_ADC_CTRL_AVG_EN
    logic [WIDTH+1:0] acc, acc_n;
    logic [1:0]       conv, conv_n;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= IW'(WIDTH-1);
            cnt        <= 4'd0;
            dac_code_o <= '0;
            result_o   <= '0;
            sample_o   <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
`ifdef SAR_ADC_CTRL_AVG_EN
            acc        <= '0;
            conv       <= 2'd0;
`endif
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            dac_code_o <= dac_n;
            result_o   <= result_n;
            sample_o   <= sample_n;
            busy_o     <= busy_n;
            done_o     <= done_n;
`ifdef SAR_ADC_CTRL_AVG_EN
            acc        <= acc_n;
            conv       <= conv_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        cnt_n    = cnt;
        dac_n    = dac_code_o;
        result_n = result_o;
        sample_n = 1'b0;
        busy_n   = busy_o;
        done_n   = 1'b0;
`ifdef SAR_ADC_CTRL_AVG_EN
        acc_n    = acc;
        conv_n   = conv;
`endif
        mask     = ONE << idx;
        // Bit under test survives only if the input is at or above the trial level
        code_dec = cmp_i ? dac_code_o : (dac_code_o & ~mask);

        case (state)
            IDLE: begin
                if (start_i) begin
                    state_n  = SAMPLE;
                    sample_n = 1'b1;
                    busy_n   = 1'b1;
                    dac_n    = '0;
`ifdef SAR_ADC_CTRL_AVG_EN
                    acc_n    = '0;
                    conv_n   = 2'd0;
`endif
                end
            end
            SAMPLE: begin
                dac_n   = ONE << (WIDTH-1);
                cnt_n   = SETTLE_LD;
                idx_n   = IW'(WIDTH-1);
                state_n = TRIAL;
            end
            TRIAL: begin
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else if (idx != '0) begin
                    dac_n = code_dec | (mask >> 1);
                    cnt_n = SETTLE_LD;
                    idx_n = idx - 1'b1;
                end else begin
                    dac_n = code_dec;
`ifdef SAR_ADC_CTRL_AVG_EN
                    // The last conversion is summed in ACCUM so DONE sees the full total
                    if (conv == 2'd3) begin
                        state_n = ACCUM;
                    end else begin
                        acc_n    = acc + {2'b00, code_dec};
                        conv_n   = conv + 2'd1;
                        state_n  = SAMPLE;
                        sample_n = 1'b1;
                        dac_n    = '0;
                    end
`else
                    state_n = DONE;
`endif
                end
            end
            ACCUM: begin
`ifdef SAR_ADC_CTRL_AVG_EN
                acc_n = acc + {2'b00, dac_code_o};
`endif
                state_n = DONE;
            end
            DONE: begin
`ifdef SAR_ADC_CTRL_AVG_EN
                result_n = acc[WIDTH+1:2];
`else
                result_n = dac_code_o;
`endif
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
                // A start seen alongside completion chains straight into the next conversion
                if (start_i) begin
                    state_n  = SAMPLE;
                    sample_n = 1'b1;
                    busy_n   = 1'b1;
                    dac_n    = '0;
`ifdef SAR_ADC_CTRL_AVG_EN
                    acc_n    = '0;
                    conv_n   = 2'd0;
`endif
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Scoreboard bench for sar_adc_ctrl with an ideal comparator model (cmp = vin >= dac code).
module tb_sar_adc_ctrl;

`ifdef SAR_ADC_CTRL_AVG_EN
    localparam int NCONV = 4;
    localparam int LAT   = 70;
`else
    localparam int NCONV = 1;
    localparam int LAT   = 18;
`endif

    logic       clk = 1'b0;
    logic       rst, start;
    logic [7:0] vin;
    logic       cmp, sample, busy, done;
    logic [7:0] dac, result;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_sample = 0;
    int n_done = 0;
    int done_cyc[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    assign cmp = (vin >= dac);

    sar_adc_ctrl #(.WIDTH(8), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .start_i(start), .cmp_i(cmp),
        .sample_o(sample), .dac_code_o(dac), .busy_o(busy),
        .done_o(done), .result_o(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every done_o pops one expected result
    always @(negedge clk) begin
        if (sample) n_sample++;
        if (done) begin
            n_done++;
            done_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: result_o=%0h, expected no done_o", result);
            end else begin
                exp_v = exp_q.pop_front();
                check("result", {24'd0, result}, {24'd0, exp_v});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int limit);
        int k = 0;
        while (!done && k < limit) begin
            step(1);
            k++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: done_o=0 after %0d cycles, expected 1", limit);
        end
        step(1);
    endtask

    task automatic convert(input logic [7:0] v);
        vin = v;
        exp_q.push_back(v);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done(LAT + 10);
    endtask

    logic [7:0] seq_a5 [8] = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
    int e, s0, d0;
    logic busy_ok;

    initial begin
        rst = 1'b1; start = 1'b0; vin = 8'h00;
        step(3);
        rst = 1'b0;
        check("rst_sample", {31'd0, sample}, 0);
        check("rst_dac", {24'd0, dac}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_result", {24'd0, result}, 0);
        step(2);

        // 0xA5: trial sequence, latency and busy window
        vin = 8'hA5;
        exp_q.push_back(8'hA5);
        start = 1'b1;
        step(1);
        e = cyc;
        start = 1'b0;
        check("acc_busy", {31'd0, busy}, 1);
        check("acc_sample", {31'd0, sample}, 1);
        check("acc_dac", {24'd0, dac}, 0);
        for (int k = 0; k < 8; k++) begin
            step(1);
            check($sformatf("trial%0d", k), {24'd0, dac}, {24'd0, seq_a5[k]});
            step(1);
        end
        busy_ok = 1'b1;
        while (cyc < e + LAT - 1) begin
            busy_ok &= busy;
            step(1);
        end
        check("busy_window", {31'd0, busy_ok & busy}, 1);
        check("done_early", {31'd0, done}, 0);
        step(1);
        check("done_at_lat", {31'd0, done}, 1);
        check("busy_drop", {31'd0, busy}, 0);
        step(2);

        convert(8'h00);
        convert(8'hFF);
        convert(8'h80);

        // Start held high: back-to-back conversions with no idle gap
        s0 = n_sample; d0 = n_done;
        done_cyc.delete();
        vin = 8'h3C;
        repeat (3) exp_q.push_back(8'h3C);
        start = 1'b1;
        step(1);
        e = cyc;
        busy_ok = 1'b1;
        while (cyc < e + 3*LAT - 1) begin
            busy_ok &= busy;
            step(1);
        end
        start = 1'b0;
        step(3);
        check("b2b_busy", {31'd0, busy_ok}, 1);
        check("b2b_done_cnt", n_done - d0, 3);
        check("b2b_sample_cnt", n_sample - s0, 3*NCONV);
        if (done_cyc.size() == 3) begin
            check("b2b_first", done_cyc[0] - e, LAT);
            check("b2b_period1", done_cyc[1] - done_cyc[0], LAT);
            check("b2b_period2", done_cyc[2] - done_cyc[1], LAT);
        end

        // Reset mid-conversion aborts without done_o
        d0 = n_done;
        vin = 8'h77;
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("abort_sample", {31'd0, sample}, 0);
        check("abort_dac", {24'd0, dac}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_done", {31'd0, done}, 0);
        check("abort_result", {24'd0, result}, 0);
        step(LAT + 5);
        check("abort_no_done", n_done - d0, 0);
        convert(8'h77);

        // Start re-pulsed while busy is ignored
        s0 = n_sample; d0 = n_done;
        vin = 8'h5A;
        exp_q.push_back(8'h5A);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(2);
        start = 1'b1;
        step(1);
        start = 1'b0;
        wait_done(LAT + 10);
        step(LAT + 5);
        check("ign_done_cnt", n_done - d0, 1);
        check("ign_sample_cnt", n_sample - s0, NCONV);

`ifdef SAR_ADC_CTRL_AVG_EN
        begin
            logic [7:0] avg_in [4] = '{8'h10, 8'h11, 8'h12, 8'h14};
            s0 = n_sample; d0 = n_done;
            exp_q.push_back(8'h11);
            start = 1'b1;
            for (int k = 0; k < 4; k++) begin
                int t = 0;
                while (!sample && t < 100) begin
                    step(1);
                    t++;
                end
                start = 1'b0;
                check($sformatf("avg_sample%0d", k), {31'd0, sample}, 1);
                vin = avg_in[k];
                step(1);
            end
            wait_done(LAT + 10);
            step(5);
            check("avg_done_cnt", n_done - d0, 1);
            check("avg_sample_cnt", n_sample - s0, 4);
        end
`endif

        step(3);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
